// File: rtl/soc_mgmt_syscfg_apb_demux.sv
// APB 1-to-NumSub demux for the syscfg subordinates: local decode-error response,
// per-access PREADY watchdog, and a last-error log with a saturating error count.
module soc_mgmt_syscfg_apb_demux #(
    parameter int unsigned NumSub     = 5,
    parameter int unsigned IdxW       = 3,
    parameter int unsigned AddrW      = 19,
    parameter int unsigned DataW      = 32,
    parameter int unsigned TimeoutCyc = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_psel,
    input  logic                    i_penable,
    input  logic                    i_pwrite,
    input  logic [AddrW-1:0]        i_paddr,
    input  logic [DataW-1:0]        i_pwdata,
    input  logic [DataW/8-1:0]      i_pstrb,
    input  logic [2:0]              i_pprot,
    output logic                    o_pready,
    output logic [DataW-1:0]        o_prdata,
    output logic                    o_pslverr,
    input  logic [IdxW-1:0]         i_dec_idx,
    input  logic                    i_dec_err,
    output logic [NumSub-1:0]       o_sub_psel,
    output logic                    o_sub_penable,
    output logic                    o_sub_pwrite,
    output logic [AddrW-1:0]        o_sub_paddr,
    output logic [DataW-1:0]        o_sub_pwdata,
    output logic [DataW/8-1:0]      o_sub_pstrb,
    output logic [2:0]              o_sub_pprot,
    input  logic [NumSub-1:0]       i_sub_pready,
    input  logic [NumSub*DataW-1:0] i_sub_prdata,
    input  logic [NumSub-1:0]       i_sub_pslverr,
    output logic                    o_err_valid,
    output logic [AddrW-1:0]        o_err_addr,
    output logic [1:0]              o_err_cause,
    output logic [7:0]              o_err_cnt,
    input  logic                    i_err_clr
);

    localparam int unsigned CntW = $clog2(TimeoutCyc);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCyc - 1);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DERR
    } state_t;

    state_t          state, state_nxt;
    logic [IdxW-1:0] idx_q, idx_nxt;
    logic [CntW-1:0] tmo_cnt, tmo_nxt;
    logic            setup, dec_bad;
    logic            sel_ready, sel_err;
    logic [DataW-1:0] sel_rdata;
    logic [1:0]      cause_now;
    logic            err_now;

    function automatic logic [NumSub-1:0] onehot(input logic [IdxW-1:0] idx);
        logic [NumSub-1:0] oh;
        oh = '0;
        for (int unsigned k = 0; k < NumSub; k++) begin
            if (32'(idx) == k) oh[k] = 1'b1;
        end
        return oh;
    endfunction

    assign setup   = i_psel & ~i_penable;
    assign dec_bad = i_dec_err | (32'(i_dec_idx) >= NumSub);

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned k = 0; k < NumSub; k++) begin
            if (32'(idx_q) == k) begin
                sel_ready = i_sub_pready[k];
                sel_err   = i_sub_pslverr[k];
                sel_rdata = i_sub_prdata[k*DataW +: DataW];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx_q;
        tmo_nxt       = tmo_cnt;
        o_sub_psel    = '0;
        o_sub_penable = 1'b0;
        o_pready      = 1'b0;
        o_prdata      = '0;
        o_pslverr     = 1'b0;
        cause_now     = 2'd0;
        case (state)
            IDLE: begin
                tmo_nxt = '0;
                if (setup) begin
                    if (dec_bad) begin
                        state_nxt = DERR;
                    end else begin
                        state_nxt  = FWD;
                        idx_nxt    = i_dec_idx;
                        o_sub_psel = onehot(i_dec_idx);
                    end
                end
            end
            FWD: begin
                o_sub_psel    = onehot(idx_q);
                o_sub_penable = i_penable;
                if (i_penable) begin
                    // subordinate PREADY beats the watchdog when both land together
                    if (sel_ready) begin
                        o_pready  = 1'b1;
                        o_prdata  = sel_rdata;
                        o_pslverr = sel_err;
                        cause_now = 2'd3;
                        state_nxt = IDLE;
                    end else if (tmo_cnt == CntLast) begin
                        o_pready   = 1'b1;
                        o_pslverr  = 1'b1;
                        o_sub_psel = '0;
                        cause_now  = 2'd2;
                        state_nxt  = IDLE;
                    end else begin
                        o_prdata = sel_rdata;
                        tmo_nxt  = tmo_cnt + 1'b1;
                    end
                end
            end
            DERR: begin
                if (i_penable) begin
                    o_pready  = 1'b1;
                    o_pslverr = 1'b1;
                    cause_now = 2'd1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign err_now = o_pready & o_pslverr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            idx_q       <= '0;
            tmo_cnt     <= '0;
            o_err_valid <= 1'b0;
            o_err_addr  <= '0;
            o_err_cause <= 2'd0;
            o_err_cnt   <= 8'd0;
        end else begin
            state   <= state_nxt;
            idx_q   <= idx_nxt;
            tmo_cnt <= tmo_nxt;
            if (err_now) begin
                o_err_valid <= 1'b1;
                o_err_addr  <= i_paddr;
                o_err_cause <= cause_now;
                if (i_err_clr) begin
                    o_err_cnt <= 8'd1;
                end else if (o_err_cnt != 8'hFF) begin
                    o_err_cnt <= o_err_cnt + 8'd1;
                end
            end else if (i_err_clr) begin
                o_err_valid <= 1'b0;
                o_err_cause <= 2'd0;
                o_err_cnt   <= 8'd0;
            end
        end
    end

    assign o_sub_pwrite = i_pwrite;
    assign o_sub_paddr  = i_paddr;
    assign o_sub_pwdata = i_pwdata;
    assign o_sub_pstrb  = i_pstrb;
    assign o_sub_pprot  = i_pprot;

endmodule
